cmos_frame_buf_ctrl: RTL and testbench
======================================

# cmos_frame_buf_ctrl

Ping-pong frame-buffer scheduler between the CMOS capture stage and the motion-detection reader. It takes the 16-bit RGB565 pixel stream and frame/line strobes from the capture block. It produces bank-tagged write addresses into a two-bank frame store, and it arbitrates bank ownership so the reader always receives a complete, unmodified frame while capture continues into the other bank.

## Interface
- H_PIX, 640, active pixels per line
- V_PIX, 480, active lines per frame
- ADDR_W, 19, pixel-address width within one bank (must satisfy 2^ADDR_W >= H_PIX*V_PIX)

- cam_pclk  in  1  pixel clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- frame_vsync  in  1  high for the whole active frame; rising edge = SOF, falling edge = EOF
- frame_href  in  1  line active (informational; not used for addressing)
- frame_valid  in  1  one-cycle strobe, pixel on frame_data valid
- frame_data  in  16  RGB565 pixel
- wr_en  out  1  frame-store write strobe
- wr_addr  out  ADDR_W+1  {bank, pixel index}
- wr_data  out  16  pixel to write
- rd_req  in  1  reader requests a frame (level, held until grant)
- rd_grant  out  1  one-cycle grant pulse
- rd_bank  out  1  bank granted to reader, stable while locked
- rd_done  in  1  one-cycle pulse, reader releases its bank
- frame_ready  out  1  a complete unread frame is available
- frame_cnt  out  16  committed frames (stats)
- drop_cnt  out  16  discarded or overwritten frames (stats)

## Operation
- FSM states: IDLE, CAPTURE, COMMIT.
  - IDLE -> CAPTURE on SOF.
  - CAPTURE -> COMMIT on EOF.
  - COMMIT -> IDLE after 1 cycle.
- SOF edge detection: frame_vsync is registered once; SOF = vs & ~vs_d.
- Write-bank selection at SOF:
  - If the reader holds a lock, use the unlocked bank.
  - Otherwise, use the bank that is not the latest full bank.
  - If no full bank exists, use bank 0.
- CAPTURE:
  - Each frame_valid writes frame_data at the current pixel index, then the index increments.
  - Pixels beyond H_PIX*V_PIX-1 are not written (wr_en stays low) and set a length-error flag.
- COMMIT:
  - If the pixel count equals H_PIX*V_PIX and there was no overflow: the bank becomes the latest full bank, frame_ready is set, and frame_cnt increments.
  - Otherwise: the frame is discarded and drop_cnt increments.
  - If a full, unread frame is overwritten by a new commit: drop_cnt also increments.
- Reader arbitration:
  - When rd_req=1, frame_ready=1, and no lock is held: pulse rd_grant, set rd_bank = latest full bank, take the lock, and clear frame_ready.
  - rd_done releases the lock.
- SOF while in CAPTURE: the partial frame is discarded (drop_cnt+1) and capture restarts with the index at 0 in the same bank.
- Counters saturate at 16'hFFFF.

## Timing
- Reset values: all outputs 0; FSM in IDLE; no lock; no full bank.
- Write path:
  - wr_en, wr_addr, and wr_data are registered.
  - 1-cycle latency from frame_valid.
- Grant path:
  - rd_grant asserts 1 cycle after the cycle in which rd_req && frame_ready && !lock is sampled.
  - rd_bank is valid in the same cycle as rd_grant.
- EOF and rd_req in the same cycle: arbitration uses pre-commit state. A grant is issued only if a previous full frame exists; otherwise the grant comes 1 cycle after COMMIT.
- rd_done and rd_req in the same cycle: rd_done is processed first. The grant may follow on the next cycle.
- rd_done with no lock held: ignored.
- SOF in the same cycle as rd_done: bank selection sees the lock as still held.
- Reset mid-frame: all state clears immediately and no partial commit occurs.

## Configuration
- FRAME_STATS_EN defined: frame_cnt and drop_cnt are live saturating counters.
- FRAME_STATS_EN undefined: both ports are tied to 16'd0 and no counter flops are generated. All other behaviour is identical.

## Structure
- Package cmos_buf_pkg holds:
  - the FSM state enum (IDLE, CAPTURE, COMMIT)
  - the FRAME_PIX constant (H_PIX*V_PIX)
  - the counter width constant STAT_W=16
- One sub-module, frame_edge_det: registers frame_vsync and outputs sof/eof pulses.

## Test plan
- Use H_PIX=4, V_PIX=2.
- Normal frame: 8 valid pixels in frame 1 -> wr_addr 0..7 in bank 0, wr_data matches; frame_ready=1 after EOF; frame_cnt=1.
- Grant and lock: after the frame above, pulse rd_req -> rd_grant 1 cycle later with rd_bank=0. A second frame writes bank 1. A third frame writes bank 1 again and drop_cnt=1. rd_done releases; the next SOF selects bank 0.
- Short frame: 6 pixels, then EOF -> no commit; frame_ready stays 0; drop_cnt+1.
- Long frame: 10 pixels -> only 8 wr_en pulses; frame discarded; drop_cnt+1.
- Simultaneous EOF and rd_req with no prior full frame -> no grant in that cycle; rd_grant arrives 1 cycle after COMMIT with the new bank.
- Reset asserted mid-CAPTURE at pixel 3 -> all outputs 0 immediately; the next complete frame writes bank 0 starting at address 0.

Source files
------------

// File: rtl/cmos_buf_pkg.sv
// Shared types and constants for the CMOS ping-pong frame-buffer scheduler.
// Optional statistics counters are enabled with the FRAME_STATS_EN macro.
package cmos_buf_pkg;

    typedef enum logic [1:0] {IDLE, CAPTURE, COMMIT} fsm_state_e;

    localparam int H_PIX_DEF = 640;
    localparam int V_PIX_DEF = 480;
    localparam int FRAME_PIX = H_PIX_DEF * V_PIX_DEF;
    localparam int STAT_W    = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/frame_edge_det.sv
// Start/end-of-frame pulse generation from the capture-side vsync level.
module frame_edge_det (
    input  logic cam_pclk,
    input  logic rst_n,
    input  logic frame_vsync,
    output logic sof,
    output logic eof
);

    logic vs_d;

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) vs_d <= 1'b0;
        else        vs_d <= frame_vsync;
    end

    assign sof = frame_vsync & ~vs_d;
    assign eof = ~frame_vsync & vs_d;

endmodule

// File: rtl/cmos_frame_buf_ctrl.sv
// Two-bank ping-pong frame-store scheduler: bank-tagged pixel writes plus reader lock arbitration.
// Define FRAME_STATS_EN to build live saturating frame_cnt/drop_cnt counters.
module cmos_frame_buf_ctrl
    import cmos_buf_pkg::*;
#(
    parameter int H_PIX  = H_PIX_DEF,
    parameter int V_PIX  = V_PIX_DEF,
    parameter int ADDR_W = 19
) (
    input  logic              cam_pclk,
    input  logic              rst_n,
    input  logic              frame_vsync,
    input  logic              frame_href,
    input  logic              frame_valid,
    input  logic [15:0]       frame_data,
    output logic              wr_en,
    output logic [ADDR_W:0]   wr_addr,
    output logic [15:0]       wr_data,
    input  logic              rd_req,
    output logic              rd_grant,
    output logic              rd_bank,
    input  logic              rd_done,
    output logic              frame_ready,
    output logic [STAT_W-1:0] frame_cnt,
    output logic [STAT_W-1:0] drop_cnt
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] N_PIX = CNT_W'(H_PIX * V_PIX);

    fsm_state_e       state;
    logic [CNT_W-1:0] pix_cnt;
    logic             wr_bank, lock, full_vld, full_bank, len_err;
    logic             sof, eof;
    logic             unused_href;

    assign unused_href = frame_href;

    frame_edge_det u_edge_det (
        .cam_pclk    (cam_pclk),
        .rst_n       (rst_n),
        .frame_vsync (frame_vsync),
        .sof         (sof),
        .eof         (eof)
    );

    logic pix_room, commit_ok, lock_eff, grant_now, sel_bank;

    assign pix_room  = pix_cnt < N_PIX;
    assign commit_ok = (state == COMMIT) && (pix_cnt == N_PIX) && !len_err;
    // rd_done frees the lock before arbitration; a commit in progress counts as ready
    assign lock_eff  = lock && !rd_done;
    assign grant_now = rd_req && (frame_ready || commit_ok) && !lock_eff;
    // Bank selection deliberately uses the registered lock, so a same-cycle rd_done still blocks
    assign sel_bank  = lock ? ~rd_bank : (full_vld ? ~full_bank : 1'b0);

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pix_cnt     <= '0;
            wr_bank     <= 1'b0;
            lock        <= 1'b0;
            full_vld    <= 1'b0;
            full_bank   <= 1'b0;
            len_err     <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            rd_grant    <= 1'b0;
            rd_bank     <= 1'b0;
            frame_ready <= 1'b0;
        end else begin
            wr_en    <= 1'b0;
            rd_grant <= 1'b0;
            case (state)
                IDLE: begin
                    if (sof) begin
                        state   <= CAPTURE;
                        wr_bank <= sel_bank;
                        pix_cnt <= '0;
                        len_err <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (sof) begin
                        pix_cnt <= '0;
                        len_err <= 1'b0;
                    end else if (eof) begin
                        state <= COMMIT;
                    end else if (frame_valid) begin
                        if (pix_room) begin
                            wr_en   <= 1'b1;
                            wr_addr <= {wr_bank, pix_cnt[ADDR_W-1:0]};
                            wr_data <= frame_data;
                            pix_cnt <= pix_cnt + CNT_W'(1);
                        end else begin
                            len_err <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    if (commit_ok) begin
                        full_vld  <= 1'b1;
                        full_bank <= wr_bank;
                    end
                end
                default: state <= IDLE;
            endcase

            if (grant_now) begin
                rd_grant    <= 1'b1;
                rd_bank     <= commit_ok ? wr_bank : full_bank;
                lock        <= 1'b1;
                frame_ready <= 1'b0;
            end else begin
                if (rd_done)   lock        <= 1'b0;
                if (commit_ok) frame_ready <= 1'b1;
            end
        end
    end

`ifdef FRAME_STATS_EN
    logic [STAT_W-1:0] frame_cnt_q, drop_cnt_q;
    logic              drop_evt;

    // Restarted capture, failed commit, or a commit landing on an unread frame
    assign drop_evt = ((state == CAPTURE) && sof) ||
                      ((state == COMMIT) && (!commit_ok || frame_ready));

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (commit_ok) frame_cnt_q <= sat_inc(frame_cnt_q);
            if (drop_evt)  drop_cnt_q  <= sat_inc(drop_cnt_q);
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`else
    assign frame_cnt = '0;
    assign drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_cmos_frame_buf_ctrl.sv
// Directed bench for cmos_frame_buf_ctrl with a write-port scoreboard (H_PIX=4, V_PIX=2).
module tb_cmos_frame_buf_ctrl;

    localparam int NPIX = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_vsync = 1'b0, frame_href = 1'b0, frame_valid = 1'b0;
    logic [15:0] frame_data = '0;
    logic        rd_req = 1'b0, rd_done = 1'b0;
    logic        wr_en, rd_grant, rd_bank, frame_ready;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data, frame_cnt, drop_cnt;

    int checks = 0;
    int errors = 0;
    int wr_seen = 0;
    logic [19:0] exp_q[$];
    logic [19:0] mon_exp;

    cmos_frame_buf_ctrl #(.H_PIX(4), .V_PIX(2), .ADDR_W(3)) dut (
        .cam_pclk    (clk),
        .rst_n       (rst_n),
        .frame_vsync (frame_vsync),
        .frame_href  (frame_href),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_req      (rd_req),
        .rd_grant    (rd_grant),
        .rd_bank     (rd_bank),
        .rd_done     (rd_done),
        .frame_ready (frame_ready),
        .frame_cnt   (frame_cnt),
        .drop_cnt    (drop_cnt)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [15:0] stat(int n);
`ifdef FRAME_STATS_EN
        return 16'(n);
`else
        return 16'd0;
`endif
    endfunction

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame();
        frame_vsync = 1'b1;
        cyc(1);
    endtask

    task automatic pixels(int n, logic bank);
        for (int i = 0; i < n; i++) begin
            frame_valid = 1'b1;
            frame_href  = 1'b1;
            frame_data  = 16'($urandom);
            if (i < NPIX) exp_q.push_back({bank, 3'(i), frame_data});
            cyc(1);
            frame_valid = 1'b0;
            frame_href  = 1'b0;
            cyc(1);
        end
    endtask

    task automatic end_frame();
        frame_vsync = 1'b0;
        cyc(2);
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_wr_en"},   32'(wr_en), 0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
        chk({tag, "_wr_data"}, 32'(wr_data), 0);
        chk({tag, "_grant"},   32'(rd_grant), 0);
        chk({tag, "_rd_bank"}, 32'(rd_bank), 0);
        chk({tag, "_ready"},   32'(frame_ready), 0);
        chk({tag, "_fcnt"},    32'(frame_cnt), 0);
        chk({tag, "_dcnt"},    32'(drop_cnt), 0);
    endtask

    // Write-port monitor: every wr_en must match the next expected {addr, data}
    always @(negedge clk) begin
        if (wr_en) begin
            wr_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL wr_unexpected: observed addr %0h data %0h expected no write", wr_addr, wr_data);
            end else begin
                mon_exp = exp_q.pop_front();
                assert ({wr_addr, wr_data} === mon_exp)
                else begin
                    errors++;
                    $error("FAIL wr_port: observed %0h expected %0h", {wr_addr, wr_data}, mon_exp);
                end
            end
        end
    end

    initial begin
        cyc(2);
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        cyc(1);

        // Frame 1 into bank 0
        wr_seen = 0;
        start_frame();
        pixels(8, 1'b0);
        end_frame();
        chk("f1_wr_count", 32'(wr_seen), 8);
        chk("f1_ready", 32'(frame_ready), 1);
        chk("f1_fcnt", 32'(frame_cnt), 32'(stat(1)));

        // Grant and lock bank 0
        rd_req = 1'b1;
        cyc(1);
        chk("g1_grant", 32'(rd_grant), 1);
        chk("g1_bank", 32'(rd_bank), 0);
        chk("g1_ready", 32'(frame_ready), 0);
        rd_req = 1'b0;
        cyc(1);
        chk("g1_pulse", 32'(rd_grant), 0);

        // Frames 2 and 3 go to bank 1 while bank 0 is locked
        start_frame();
        pixels(8, 1'b1);
        end_frame();
        chk("f2_ready", 32'(frame_ready), 1);
        chk("f2_fcnt", 32'(frame_cnt), 32'(stat(2)));
        chk("f2_dcnt", 32'(drop_cnt), 32'(stat(0)));
        start_frame();
        pixels(8, 1'b1);
        end_frame();
        chk("f3_fcnt", 32'(frame_cnt), 32'(stat(3)));
        chk("f3_dcnt", 32'(drop_cnt), 32'(stat(1)));

        // Release; next frame selects bank 0
        rd_done = 1'b1;
        cyc(1);
        rd_done = 1'b0;
        start_frame();
        pixels(8, 1'b0);
        end_frame();
        chk("f4_fcnt", 32'(frame_cnt), 32'(stat(4)));
        chk("f4_dcnt", 32'(drop_cnt), 32'(stat(2)));
        rd_req = 1'b1;
        cyc(1);
        chk("g2_grant", 32'(rd_grant), 1);
        chk("g2_bank", 32'(rd_bank), 0);
        rd_req = 1'b0;
        cyc(1);

        // Short frame: discarded
        wr_seen = 0;
        start_frame();
        pixels(6, 1'b1);
        end_frame();
        chk("short_wr_count", 32'(wr_seen), 6);
        chk("short_ready", 32'(frame_ready), 0);
        chk("short_fcnt", 32'(frame_cnt), 32'(stat(4)));
        chk("short_dcnt", 32'(drop_cnt), 32'(stat(3)));

        // Long frame: only 8 writes, discarded
        wr_seen = 0;
        start_frame();
        pixels(10, 1'b1);
        end_frame();
        chk("long_wr_count", 32'(wr_seen), 8);
        chk("long_ready", 32'(frame_ready), 0);
        chk("long_dcnt", 32'(drop_cnt), 32'(stat(4)));

        // EOF together with rd_req and no unread frame
        rd_done = 1'b1;
        cyc(1);
        rd_done = 1'b0;
        start_frame();
        pixels(8, 1'b1);
        frame_vsync = 1'b0;
        rd_req = 1'b1;
        cyc(1);
        chk("eof_req_no_grant", 32'(rd_grant), 0);
        cyc(1);
        chk("eof_req_grant", 32'(rd_grant), 1);
        chk("eof_req_bank", 32'(rd_bank), 1);
        chk("eof_req_ready", 32'(frame_ready), 0);
        chk("eof_req_fcnt", 32'(frame_cnt), 32'(stat(5)));
        rd_req = 1'b0;
        cyc(1);

        // Reset mid-capture at pixel 3
        start_frame();
        pixels(3, 1'b0);
        frame_valid = 1'b1;
        frame_data  = 16'hBEEF;
        frame_vsync = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        frame_valid = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        wr_seen = 0;
        start_frame();
        pixels(8, 1'b0);
        end_frame();
        chk("post_rst_wr_count", 32'(wr_seen), 8);
        chk("post_rst_ready", 32'(frame_ready), 1);
        chk("post_rst_fcnt", 32'(frame_cnt), 32'(stat(1)));
        chk("post_rst_dcnt", 32'(drop_cnt), 32'(stat(0)));

        cyc(2);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
